// File: rtl/mult_hilo_ctrl.sv
// HI/LO multiply controller: conditions operands, sequences an external
// shift-add multiplier, fixes the sign and writes the HI/LO registers.
module mult_hilo_ctrl #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   input  logic        op_signed,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   input  logic [1:0]  mf_sel,
   output logic [31:0] rd_data,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        wr_done,
   output logic        err,
   output logic        mul_st,
   output logic [15:0] mul_multiplicando,
   output logic [15:0] mul_multiplicador,
   input  logic [31:0] mul_produto,
   input  logic        mul_done,
   input  logic        mul_idle
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IDLE,
      S_START,
      S_WAIT_DONE,
      S_FIX,
      S_WRITE
   } state_t;

   state_t         state;
   state_t         nxt;
   logic [CW-1:0]  cnt;
   logic           cnt_hit;
   logic           tmo;
   logic           accept;
   logic           neg_q;
   logic           sgn_q;
   logic [31:0]    p_q;
   logic [15:0]    a_mag;
   logic [15:0]    b_mag;

   assign cnt_hit = (cnt == CW'(TIMEOUT - 1));
   assign accept  = (state == S_IDLE) && op_valid;
   assign busy    = (state != S_IDLE);
   assign wr_done = (state == S_WRITE);
   assign mul_st  = (state == S_START);

   // magnitude of each operand; 0x8000 negates to itself (32768 unsigned)
   always_comb begin
      a_mag = op_a;
      b_mag = op_b;
      if (op_signed && op_a[15]) a_mag = ~op_a + 16'd1;
      if (op_signed && op_b[15]) b_mag = ~op_b + 16'd1;
   end

   // next state; a done pulse wins over a coincident timeout
   always_comb begin
      nxt = state;
      tmo = 1'b0;
      case (state)
         S_IDLE: begin
            if (op_valid) nxt = S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (mul_idle) nxt = S_START;
         end
         S_START: begin
            if (cnt_hit) begin
               nxt = S_IDLE;
               tmo = 1'b1;
            end else if (!mul_idle) begin
               nxt = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (mul_done) begin
               nxt = S_FIX;
            end else if (cnt_hit) begin
               nxt = S_IDLE;
               tmo = 1'b1;
            end
         end
         S_FIX:   nxt = S_WRITE;
         S_WRITE: nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   // operand magnitudes and sign info, held for the whole operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_multiplicando <= '0;
         mul_multiplicador <= '0;
         neg_q             <= 1'b0;
         sgn_q             <= 1'b0;
      end else if (accept) begin
         mul_multiplicando <= a_mag;
         mul_multiplicador <= b_mag;
         neg_q             <= op_signed & (op_a[15] ^ op_b[15]);
         sgn_q             <= op_signed;
      end
   end

   // timeout counter: zeroed entering START, runs through WAIT_DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state != S_START && nxt == S_START) begin
         cnt <= '0;
      end else if (state == S_START || state == S_WAIT_DONE) begin
         cnt <= cnt + CW'(1);
      end
   end

   // product capture and sign fix (negating zero stays zero)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= '0;
      end else if (state == S_WAIT_DONE && mul_done) begin
         p_q <= mul_produto;
      end else if (state == S_FIX && neg_q) begin
         p_q <= ~p_q + 32'd1;
      end
   end

   // HI/LO become visible the cycle after the write pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else if (state == S_WRITE) begin
         lo <= p_q;
         hi <= (sgn_q && p_q[31]) ? 32'hFFFF_FFFF : 32'h0;
      end
   end

   // sticky timeout flag, cleared by the next accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      err <= 1'b0;
      else if (accept) err <= 1'b0;
      else if (tmo)    err <= 1'b1;
   end

   // MFHI / MFLO read port
   always_comb begin
      rd_data = '0;
      case (mf_sel)
         2'b01:   rd_data = hi;
         2'b10:   rd_data = lo;
         default: rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Scoreboard bench for mult_hilo_ctrl with a behavioural
// variable-latency multiplier model.
module tb_mult_hilo_ctrl;

   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_signed = 1'b0;
   logic [15:0] op_a = '0;
   logic [15:0] op_b = '0;
   logic [1:0]  mf_sel = 2'b00;
   logic [31:0] rd_data, hi, lo;
   logic        busy, wr_done, err, mul_st;
   logic [15:0] mul_multiplicando, mul_multiplicador;
   logic [31:0] mul_produto;
   logic        mul_done, mul_idle;

   mult_hilo_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .op_valid(op_valid), .op_signed(op_signed),
      .op_a(op_a), .op_b(op_b), .mf_sel(mf_sel),
      .rd_data(rd_data), .hi(hi), .lo(lo),
      .busy(busy), .wr_done(wr_done), .err(err),
      .mul_st(mul_st),
      .mul_multiplicando(mul_multiplicando),
      .mul_multiplicador(mul_multiplicador),
      .mul_produto(mul_produto),
      .mul_done(mul_done), .mul_idle(mul_idle)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          fails = 0;
   int          wr_cnt = 0;
   logic [31:0] last_lo = '0;
   logic [31:0] last_hi = '0;
   logic        m_hang = 1'b0;
   int          m_lat = 2;
   int          m_cnt;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // multiplier model: accepts start when idle, answers after m_lat cycles
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_idle    <= 1'b1;
         mul_done    <= 1'b0;
         mul_produto <= '0;
         m_cnt       <= 0;
      end else begin
         mul_done <= 1'b0;
         if (mul_idle) begin
            if (mul_st) begin
               mul_idle <= 1'b0;
               m_cnt    <= m_lat;
            end
         end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
         end else if (!m_hang) begin
            mul_done    <= 1'b1;
            mul_produto <= {16'h0, mul_multiplicando}
                         * {16'h0, mul_multiplicador};
            mul_idle    <= 1'b1;
         end
      end
   end

   // monitor: compares each write against the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && wr_done) begin
            wr_cnt++;
            chk("old_lo", lo, last_lo);
            chk("old_hi", hi, last_hi);
            if (q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_wr_done actual=1 required=0");
            end else begin
               e = q.pop_front();
               @(negedge clk);
               chk("lo", lo, e.lo);
               chk("hi", hi, e.hi);
               chk("busy_after", 32'(busy), 32'd0);
               chk("wr_done_pulse", 32'(wr_done), 32'd0);
               last_lo = e.lo;
               last_hi = e.hi;
            end
         end
      end
   end

   task automatic do_op(input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic push,
                        input logic [31:0] elo, input logic [31:0] ehi);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         fails++;
         $display("FAIL busy_wait actual=busy required=idle");
      end
      op_valid  = 1'b1;
      op_signed = s;
      op_a      = a;
      op_b      = b;
      e.lo = elo;
      e.hi = ehi;
      if (push) q.push_back(e);
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((q.size() != 0 || busy) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0 || busy) begin
         checks++;
         fails++;
         $display("FAIL done_wait actual=pending required=idle");
         q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int w0;
      int k;
      int n;
      mf_sel = 2'b01;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_done", 32'(wr_done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_mul_st", 32'(mul_st), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_rd", rd_data, 32'd0);
      rst_n = 1'b1;

      do_op(1'b0, 16'd300, 16'd200, 1'b1, 32'h0000_EA60, 32'h0);
      chk("busy_set", 32'(busy), 32'd1);
      wait_done();

      m_lat = 5;
      do_op(1'b1, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 32'h0);
      chk("mcand_8000", 32'(mul_multiplicando), 32'h8000);
      chk("mplier_8000", 32'(mul_multiplicador), 32'h8000);
      wait_done();

      m_lat = 0;
      do_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001, 32'h0);
      wait_done();

      m_lat = 3;
      do_op(1'b1, 16'hFFFE, 16'hFFFD, 1'b1, 32'd6, 32'h0);
      wait_done();

      do_op(1'b1, 16'h0000, 16'hFFFB, 1'b1, 32'd0, 32'h0);
      wait_done();

      m_lat = 8;
      w0 = wr_cnt;
      do_op(1'b0, 16'd5, 16'd9, 1'b1, 32'd45, 32'h0);
      repeat (4) @(negedge clk);
      op_valid = 1'b1;
      op_a     = 16'd11;
      op_b     = 16'd13;
      @(negedge clk);
      op_valid = 1'b0;
      chk("opnd_stable", 32'(mul_multiplicando), 32'd5);
      wait_done();
      repeat (20) @(negedge clk);
      chk("single_wr", 32'(wr_cnt - w0), 32'd1);
      mf_sel = 2'b10;
      #1 chk("mflo_45", rd_data, 32'd45);

      m_lat = 2;
      do_op(1'b1, 16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1, 32'hFFFF_FFFF);
      chk("mcand_neg3", 32'(mul_multiplicando), 32'd3);
      wait_done();
      mf_sel = 2'b01;
      #1 chk("mfhi", rd_data, 32'hFFFF_FFFF);
      mf_sel = 2'b10;
      #1 chk("mflo", rd_data, 32'hFFFF_FFF1);
      mf_sel = 2'b11;
      #1 chk("mf_none", rd_data, 32'h0);

      m_lat = 10;
      do_op(1'b0, 16'd100, 16'd100, 1'b0, 32'h0, 32'h0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_mul_st", 32'(mul_st), 32'd0);
      chk("arst_hi", hi, 32'h0);
      chk("arst_lo", lo, 32'h0);
      chk("arst_mcand", 32'(mul_multiplicando), 32'h0);
      q.delete();
      last_lo = '0;
      last_hi = '0;
      @(negedge clk);
      rst_n = 1'b1;
      m_lat = 1;
      do_op(1'b0, 16'd7, 16'd6, 1'b1, 32'd42, 32'h0);
      wait_done();

      m_hang = 1'b1;
      w0 = wr_cnt;
      do_op(1'b0, 16'd3, 16'd4, 1'b0, 32'h0, 32'h0);
      n = 0;
      while (!mul_st && n < 50) begin
         @(negedge clk);
         n++;
      end
      k = 0;
      while (!err && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("tmo_cycles", 32'(k), 32'(TO));
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_busy", 32'(busy), 32'd0);
      chk("tmo_mul_st", 32'(mul_st), 32'd0);
      repeat (5) @(negedge clk);
      chk("tmo_sticky", 32'(err), 32'd1);
      chk("tmo_lo", lo, 32'd42);
      chk("tmo_hi", hi, 32'h0);
      chk("tmo_no_wr", 32'(wr_cnt - w0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/mult_hilo_ctrl.md
MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64: cycles allowed from multiplier start to Mul_Done before abort.
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 Op_Valid  input  1  one-cycle request to multiply Op_A by Op_B; sampled only when Busy=0.
REQ-005 Op_Signed  input  1  1: operands are two's complement; 0: unsigned.
REQ-006 Op_A  input  16  first operand.
REQ-007 Op_B  input  16  second operand.
REQ-008 Mf_Sel  input  2  read select: 01 MFHI, 10 MFLO, 00/11 none.
REQ-009 Rd_Data  output  32  Hi when Mf_Sel=01, Lo when 10, else 0; combinational.
REQ-010 Hi  output  32  HI register.
REQ-011 Lo  output  32  LO register.
REQ-012 Busy  output  1  operation in flight; pipeline stall.
REQ-013 Wr_Done  output  1  one-cycle pulse when Hi/Lo are written.
REQ-014 Err  output  1  sticky timeout flag; cleared by next accepted Op_Valid.
REQ-015 Mul_St  output  1  start to the 16x16 shift-add multiplier.
REQ-016 Mul_Multiplicando  output  16  magnitude of Op_A, registered.
REQ-017 Mul_Multiplicador  output  16  magnitude of Op_B, registered.
REQ-018 Mul_Produto  input  32  unsigned multiplier product.
REQ-019 Mul_Done  input  1  product valid, one-cycle pulse.
REQ-020 Mul_Idle  input  1  multiplier waiting for start.

Function
REQ-021 FSM states SHALL be IDLE, WAIT_IDLE, START, WAIT_DONE, FIX, WRITE.
REQ-022 IDLE: Busy=0; Op_Valid=1 -> latch operands and sign info, clear Err, go WAIT_IDLE (Busy=1 from next cycle).
REQ-023 Operand conditioning: if Op_Signed and bit15=1, operand register = two's-complement negation (0x8000 -> 0x8000, i.e. 32768 unsigned); else operand unchanged; Neg = Op_Signed & (A15 ^ B15).
REQ-024 WAIT_IDLE: hold Mul_St=0 until Mul_Idle=1, then go START.
REQ-025 START: Mul_St=1, held until Mul_Idle=0 (start accepted), then Mul_St=0 and go WAIT_DONE; operand outputs stable throughout START and WAIT_DONE.
REQ-026 WAIT_DONE: on Mul_Done=1 capture Mul_Produto into internal P and go FIX.
REQ-027 Timeout counter SHALL clear on entering START and increment each cycle in START/WAIT_DONE; reaching TIMEOUT -> Err=1, Mul_St=0, go IDLE, Hi/Lo unchanged, no Wr_Done.
REQ-028 FIX: if Neg, P = (~P)+1 (32-bit wrap); zero product SHALL stay 0.
REQ-029 WRITE: Lo=P; Hi = 0xFFFFFFFF if Op_Signed and P[31]=1, else 0; Wr_Done=1 this cycle; next state IDLE.
REQ-030 Latency: Op_Valid to Wr_Done = multiplier latency + 4 cycles minimum; block SHALL not assume fixed multiplier latency.
REQ-031 Op_Valid while Busy=1 SHALL be ignored (no queueing).
REQ-032 Mf_Sel read same cycle as WRITE returns old value; new value visible cycle after Wr_Done.
REQ-033 Mul_Done outside WAIT_DONE SHALL be ignored.

Reset
REQ-034 Reset=0 at any time, including mid-operation: state IDLE, Hi=Lo=0, Busy=0, Wr_Done=0, Err=0, Mul_St=0, operand registers 0, counter 0.
REQ-035 After Reset release, first Op_Valid is accepted on the first rising edge.

Verification
REQ-036 Unsigned 300 x 200 -> Wr_Done pulse, Lo=0x0000EA60, Hi=0, Busy low next cycle.
REQ-037 Signed 0xFFFD x 0x0005 -> Mul_Multiplicando=3, Lo=0xFFFFFFF1, Hi=0xFFFFFFFF.
REQ-038 Signed 0x8000 x 0x8000 -> Mul_Multiplicando=0x8000, Lo=0x40000000, Hi=0; unsigned 0xFFFF x 0xFFFF -> Lo=0xFFFE0001, Hi=0.
REQ-039 Second Op_Valid during WAIT_DONE -> ignored, single Wr_Done, result of first operands only; Mf_Sel=10 after write -> Rd_Data=Lo.
REQ-040 Reset=0 during WAIT_DONE -> Busy, Mul_St, Hi, Lo all 0 asynchronously; new 7 x 6 after release -> Lo=42.
REQ-041 Mul_Done held 0 -> Err=1 exactly TIMEOUT cycles after entering START, Busy=0, Hi/Lo unchanged, no Wr_Done.
